// File: rtl/hardware_divider_64bit_if.sv
// Request/result bundle between core control and the iterative divider.
// Handshake: the requester raises start for a cycle while busy is low; the
// request is taken at that rising edge. busy stays high until the cycle after
// done, and quotient/remainder are valid in the single cycle done is high.
interface hardware_divider_64bit_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             alu64;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, alu64, a, b,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, alu64, a, b,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/hardware_divider_64bit.sv
// Iterative unsigned restoring divider for the eBPF ALU (DIV/MOD, ALU64 and
// ALU32). One shift-subtract step per clock, MSB first; a zero divisor skips
// straight to completion with quotient 0 and remainder equal to the dividend.
module hardware_divider_64bit #(
    parameter int WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    hardware_divider_64bit_if.slave       bus,
    output logic [1:0]                    state_dbg
);
    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] dvd;          // dividend, shifted left so the next bit sits at the MSB
    logic [WIDTH-1:0] dsr;          // latched divisor
    logic [WIDTH-1:0] rem;          // partial remainder
    logic [WIDTH-1:0] quo;          // quotient bits collected LSB-in
    logic [CNT_W-1:0] count;        // steps still to perform
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Operand masking for ALU32 and one restoring step, widened by one bit so
    // the compare is just the borrow out of the subtract.
    always_comb begin
        a_m      = bus.alu64 ? bus.a : {{HALF{1'b0}}, bus.a[HALF-1:0]};
        b_m      = bus.alu64 ? bus.b : {{HALF{1'b0}}, bus.b[HALF-1:0]};
        trial    = {rem, dvd[WIDTH-1]};
        diff     = trial - {1'b0, dsr};
        fits     = ~diff[WIDTH];
        rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, so requests while busy are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (b_m == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, publish results on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            quo         <= '0;
            count       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dsr   <= b_m;
                        rem   <= '0;
                        quo   <= '0;
                        count <= bus.alu64 ? CNT_W'(WIDTH) : CNT_W'(HALF);
                        // ALU32 dividend is pre-aligned so its bit 31 is consumed first.
                        dvd   <= bus.alu64 ? a_m : (a_m << HALF);
                        if (b_m == '0) begin
                            quotient_q  <= '0;
                            remainder_q <= a_m;
                        end
                    end
                end
                RUN: begin
                    dvd   <= dvd << 1;
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        quotient_q  <= quo_next;
                        remainder_q <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and result outputs.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.quotient  = quotient_q;
        bus.remainder = remainder_q;
        state_dbg     = state;
    end
endmodule
